poly_nco_mixer: RTL and testbench

//  Time-multiplexed N-voice oscillator bank with a summing mixer; successor to the single-voice NCO.

---
 rtl/synth_pkg.sv | 29 ++
 rtl/voice_wave_gen.sv | 65 ++++++
 rtl/poly_nco_mixer.sv | 195 +++++++++++++++++++
 tb/tb_poly_nco_mixer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and helpers for the polyphonic oscillator bank and its mixer.
package synth_pkg;

  typedef enum logic [1:0] {
    SHAPE_SQUARE = 2'd0,
    SHAPE_SAW    = 2'd1,
    SHAPE_TRI    = 2'd2,
    SHAPE_OFF    = 2'd3
  } shape_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Clamp a signed value into the range of a w-bit two's-complement number.
  function automatic int saturate(input int value, input int w);
    int hi;
    int lo;
    hi = (1 <<< (w - 1)) - 1;
    lo = -(1 <<< (w - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/voice_wave_gen.sv
// Waveform stage (registered) followed by amplitude scaling; serves one voice slot per cycle.
module voice_wave_gen
  import synth_pkg::*;
#(
  parameter int OUT_W = 16,
  parameter int AMP_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic             in_active,
  input  logic [1:0]       in_shape,
  input  logic [OUT_W-1:0] in_p,
  input  logic [AMP_W-1:0] in_amp,
  output logic             out_vld,
  output logic [OUT_W-1:0] out_sample
);

  localparam int PROD_W = OUT_W + AMP_W + 1;
  localparam logic [OUT_W-1:0] SQ_MAX = {1'b0, {(OUT_W-1){1'b1}}};

  logic                     vld_q, vld_d;
  logic [OUT_W-1:0]         wave_q, wave_d;
  logic [AMP_W-1:0]         amp_q, amp_d;
  logic [OUT_W-1:0]         tri_u;
  logic signed [PROD_W-1:0] prod;
  shape_t                   shape;

  always_comb begin
    shape  = shape_t'(in_shape);
    tri_u  = in_p[OUT_W-1] ? ~{in_p[OUT_W-2:0], 1'b0} : {in_p[OUT_W-2:0], 1'b0};
    wave_d = '0;
    if (in_vld && in_active) begin
      case (shape)
        SHAPE_SQUARE: wave_d = in_p[OUT_W-1] ? -SQ_MAX : SQ_MAX;
        SHAPE_SAW:    wave_d = {~in_p[OUT_W-1], in_p[OUT_W-2:0]};
        SHAPE_TRI:    wave_d = {~tri_u[OUT_W-1], tri_u[OUT_W-2:0]};
        default:      wave_d = '0;
      endcase
    end
    vld_d = in_vld;
    amp_d = in_amp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      wave_q <= '0;
      amp_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      wave_q <= wave_d;
      amp_q  <= amp_d;
    end
  end

  // Arithmetic shift floors the product; keeping the low OUT_W bits is the truncation.
  always_comb begin
    prod       = PROD_W'($signed(wave_q)) * PROD_W'($signed({1'b0, amp_q}));
    out_sample = OUT_W'(prod >>> AMP_W);
  end

  assign out_vld = vld_q;

endmodule

// File: rtl/poly_nco_mixer.sv
// Time-multiplexed oscillator bank: one voice per cycle through a three-stage pipeline
// into a saturating mixer, producing one mixed sample per sample_tick.
module poly_nco_mixer
  import synth_pkg::*;
#(
  parameter  int NUM_VOICES = 8,
  parameter  int PHASE_W    = 24,
  parameter  int OUT_W      = 16,
  parameter  int AMP_W      = 16,
  localparam int VIDX_W     = $clog2(NUM_VOICES)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               cfg_we,
  input  logic [VIDX_W-1:0]  cfg_voice,
  input  logic [PHASE_W-1:0] cfg_freq,
  input  logic [AMP_W-1:0]   cfg_amp,
  input  logic [1:0]         cfg_shape,
  input  logic               cfg_key_on,
  input  logic               sample_tick,
  output logic [OUT_W-1:0]   sample_out,
  output logic               sample_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int              ACC_W       = OUT_W + $clog2(NUM_VOICES) + 1;
  localparam logic [VIDX_W:0] VOICE_LIMIT = (VIDX_W + 1)'(NUM_VOICES);
  localparam logic [VIDX_W-1:0] LAST_IDX  = VIDX_W'(NUM_VOICES - 1);

  state_t                  state_q, state_d;
  logic [VIDX_W-1:0]       idx_q, idx_d;
  logic                    drain_q, drain_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0]        sample_out_q, sample_out_d;
  logic                    overrun_q, overrun_d;

  logic [PHASE_W-1:0] freq_q  [NUM_VOICES];
  logic [PHASE_W-1:0] freq_d  [NUM_VOICES];
  logic [AMP_W-1:0]   amp_q   [NUM_VOICES];
  logic [AMP_W-1:0]   amp_d   [NUM_VOICES];
  logic [1:0]         shape_q [NUM_VOICES];
  logic [1:0]         shape_d [NUM_VOICES];
  logic               key_q   [NUM_VOICES];
  logic               key_d   [NUM_VOICES];
  logic [PHASE_W-1:0] phase_q [NUM_VOICES];
  logic [PHASE_W-1:0] phase_d [NUM_VOICES];

  logic               s1_vld_q, s1_vld_d;
  logic               s1_key_q, s1_key_d;
  logic [1:0]         s1_shape_q, s1_shape_d;
  logic [OUT_W-1:0]   s1_p_q, s1_p_d;
  logic [AMP_W-1:0]   s1_amp_q, s1_amp_d;
  logic [PHASE_W-1:0] phase_new;
  logic               accept;
  logic               cfg_hit;
  logic               s3_vld;
  logic [OUT_W-1:0]   s3_sample;

  assign accept  = (state_q == IDLE) && sample_tick;
  assign cfg_hit = cfg_we && ({1'b0, cfg_voice} < VOICE_LIMIT);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          idx_d = idx_q + VIDX_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q) state_d = DONE;
        else         drain_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != IDLE);
    sample_valid = (state_q == DONE);
    sample_out   = sample_out_q;
    overrun      = overrun_q;
  end

  // The last voice's contribution lands in acc_d during the final drain cycle.
  always_comb begin
    acc_d = acc_q;
    if (accept)      acc_d = '0;
    else if (s3_vld) acc_d = acc_q + ACC_W'($signed(s3_sample));
    sample_out_d = sample_out_q;
    if (state_q == DRAIN && drain_q) sample_out_d = OUT_W'(saturate(int'(acc_d), OUT_W));
    overrun_d = overrun_q | (sample_tick & (state_q != IDLE));
  end

  always_comb begin
    phase_new  = key_q[idx_q] ? phase_q[idx_q] + freq_q[idx_q] : phase_q[idx_q];
    s1_vld_d   = (state_q == RUN);
    s1_key_d   = key_q[idx_q];
    s1_shape_d = shape_q[idx_q];
    s1_amp_d   = amp_q[idx_q];
    s1_p_d     = phase_new[PHASE_W-1 -: OUT_W];
  end

  always_comb begin
    freq_d  = freq_q;
    amp_d   = amp_q;
    shape_d = shape_q;
    key_d   = key_q;
    phase_d = phase_q;
    if (state_q == RUN) phase_d[idx_q] = phase_new;
    if (cfg_hit) begin
      freq_d[cfg_voice]  = cfg_freq;
      amp_d[cfg_voice]   = cfg_amp;
      shape_d[cfg_voice] = cfg_shape;
      key_d[cfg_voice]   = cfg_key_on;
      // Key release restarts the oscillator and wins over the read stage's write-back.
      if (key_q[cfg_voice] && !cfg_key_on) phase_d[cfg_voice] = '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      drain_q      <= 1'b0;
      acc_q        <= '0;
      sample_out_q <= '0;
      overrun_q    <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_key_q     <= 1'b0;
      s1_shape_q   <= '0;
      s1_p_q       <= '0;
      s1_amp_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      drain_q      <= drain_d;
      acc_q        <= acc_d;
      sample_out_q <= sample_out_d;
      overrun_q    <= overrun_d;
      s1_vld_q     <= s1_vld_d;
      s1_key_q     <= s1_key_d;
      s1_shape_q   <= s1_shape_d;
      s1_p_q       <= s1_p_d;
      s1_amp_q     <= s1_amp_d;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        freq_q[v]  <= '0;
        amp_q[v]   <= '0;
        shape_q[v] <= '0;
        key_q[v]   <= 1'b0;
        phase_q[v] <= '0;
      end
    end else begin
      freq_q  <= freq_d;
      amp_q   <= amp_d;
      shape_q <= shape_d;
      key_q   <= key_d;
      phase_q <= phase_d;
    end
  end

  voice_wave_gen #(
    .OUT_W(OUT_W),
    .AMP_W(AMP_W)
  ) u_wave (
    .clk       (Clk),
    .rst       (Reset),
    .in_vld    (s1_vld_q),
    .in_active (s1_key_q),
    .in_shape  (s1_shape_q),
    .in_p      (s1_p_q),
    .in_amp    (s1_amp_q),
    .out_vld   (s3_vld),
    .out_sample(s3_sample)
  );

endmodule

// File: tb/tb_poly_nco_mixer.sv
// Bench for poly_nco_mixer with four voices: directed frames plus randomized voice setups
// compared against a frame-level arithmetic model of the oscillator bank.
module tb_poly_nco_mixer;

  localparam int NV = 4;
  localparam int SQ = 0, SAW = 1, TRI = 2, OFF = 3;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_voice = '0;
  logic [23:0] cfg_freq = '0;
  logic [15:0] cfg_amp = '0;
  logic [1:0]  cfg_shape = '0;
  logic        cfg_key_on = 1'b0;
  logic        sample_tick = 1'b0;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic        overrun;

  int vectors = 0;
  int miscompares = 0;
  int valid_count = 0;

  int unsigned m_freq [NV];
  int          m_amp  [NV];
  int          m_shape[NV];
  bit          m_key  [NV];
  int unsigned m_phase[NV];

  poly_nco_mixer #(
    .NUM_VOICES(NV),
    .PHASE_W   (24),
    .OUT_W     (16),
    .AMP_W     (16)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .cfg_we      (cfg_we),
    .cfg_voice   (cfg_voice),
    .cfg_freq    (cfg_freq),
    .cfg_amp     (cfg_amp),
    .cfg_shape   (cfg_shape),
    .cfg_key_on  (cfg_key_on),
    .sample_tick (sample_tick),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (sample_valid) valid_count++;

  // Waveform value for a 16-bit phase p, from the shape definitions as plain integers.
  function automatic int wave_of(int shape, int p);
    case (shape)
      SQ:      return (p >= 32768) ? -32767 : 32767;
      SAW:     return p - 32768;
      TRI:     return (p < 32768) ? 2 * p - 32768 : 98303 - 2 * p;
      default: return 0;
    endcase
  endfunction

  function automatic int scale(int w, int amp);
    longint prod;
    prod = longint'(w) * longint'(amp);
    if (prod >= 0) return int'(prod / 65536);
    return -int'((-prod + 65535) / 65536);
  endfunction

  function automatic int model_frame();
    longint sum;
    sum = 0;
    for (int v = 0; v < NV; v++) begin
      if (m_key[v]) begin
        m_phase[v] = (m_phase[v] + m_freq[v]) % (1 << 24);
        sum += scale(wave_of(m_shape[v], int'(m_phase[v] >> 8)), m_amp[v]);
      end
    end
    if (sum > 32767)  sum = 32767;
    if (sum < -32768) sum = -32768;
    return int'(sum);
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset       = 1'b1;
    cfg_we      = 1'b0;
    sample_tick = 1'b0;
    step();
    step();
    Reset = 1'b0;
    step();
    for (int v = 0; v < NV; v++) begin
      m_freq[v] = 0; m_amp[v] = 0; m_shape[v] = 0; m_key[v] = 1'b0; m_phase[v] = 0;
    end
  endtask

  task automatic write_voice(int v, int unsigned freq, int amp, int shape, bit key);
    cfg_voice  = 2'(v);
    cfg_freq   = 24'(freq);
    cfg_amp    = 16'(amp);
    cfg_shape  = 2'(shape);
    cfg_key_on = key;
    cfg_we     = 1'b1;
    step();
    cfg_we = 1'b0;
    if (m_key[v] && !key) m_phase[v] = 0;
    m_freq[v] = freq; m_amp[v] = amp; m_shape[v] = shape; m_key[v] = key;
  endtask

  // Tick in the current cycle; lat is the cycle offset of sample_valid (-1 on timeout).
  task automatic run_frame(output int lat, output logic [15:0] got);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    lat = -1;
    got = 'x;
    for (int k = 1; k <= 20; k++) begin
      if (sample_valid) begin
        lat = k;
        got = sample_out;
        step();
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    int lat;
    logic [15:0] got;
    int vc0;
    Reset = 1'b1;
    step();
    vectors++;
    if (sample_out !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_out: got %h expected 0000", sample_out); end
    vectors++;
    if (sample_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got valid=%b busy=%b overrun=%b expected 0 0 0", sample_valid, busy, overrun);
    end
    do_reset();
    write_voice(0, 24'h100000, 16'hFFFF, SAW, 1'b1);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    step();
    vc0 = valid_count;
    Reset = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    step();
    Reset = 1'b0;
    for (int k = 0; k < 12; k++) step();
    vectors++;
    if (valid_count - vc0 !== 0) begin miscompares++; $display("[TB] FAIL abort_no_valid: got %0d pulses expected 0", valid_count - vc0); end
    run_frame(lat, got);
    vectors++;
    if (got !== 16'h0000) begin miscompares++; $display("[TB] FAIL abort_regs_cleared: got %h expected 0000", got); end
  endtask

  task automatic test_silence();
    int lat;
    logic [15:0] got;
    do_reset();
    run_frame(lat, got);
    vectors++;
    if (lat !== 7) begin miscompares++; $display("[TB] FAIL silence_latency: got %0d expected 7", lat); end
    vectors++;
    if (got !== 16'h0000) begin miscompares++; $display("[TB] FAIL silence_out: got %h expected 0000", got); end
    vectors++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL silence_idle: got busy=%b overrun=%b expected 0 0", busy, overrun);
    end
  endtask

  task automatic test_saw();
    int lat;
    logic [15:0] got;
    do_reset();
    write_voice(0, 24'h100000, 16'hFFFF, SAW, 1'b1);
    run_frame(lat, got);
    vectors++;
    if (lat !== 7 || got !== 16'h9000) begin
      miscompares++;
      $display("[TB] FAIL saw_single: got lat=%0d out=%h expected lat=7 out=9000", lat, got);
    end
  endtask

  task automatic test_saturate();
    int lat;
    logic [15:0] got;
    do_reset();
    for (int v = 0; v < NV; v++) write_voice(v, 24'h000001, 16'hFFFF, SQ, 1'b1);
    run_frame(lat, got);
    vectors++;
    if (got !== 16'h7FFF) begin miscompares++; $display("[TB] FAIL saturate_pos: got %h expected 7fff", got); end
    do_reset();
    for (int v = 0; v < NV; v++) write_voice(v, 24'h800000, 16'hFFFF, SQ, 1'b1);
    run_frame(lat, got);
    vectors++;
    if (got !== 16'h8000) begin miscompares++; $display("[TB] FAIL saturate_neg: got %h expected 8000", got); end
  endtask

  task automatic test_wrap();
    int lat;
    logic [15:0] got;
    do_reset();
    write_voice(0, 24'h800000, 16'hFFFF, SAW, 1'b1);
    run_frame(lat, got);
    vectors++;
    if (got !== 16'h0000) begin miscompares++; $display("[TB] FAIL wrap_first: got %h expected 0000", got); end
    run_frame(lat, got);
    vectors++;
    if (got !== 16'h8000) begin miscompares++; $display("[TB] FAIL wrap_second: got %h expected 8000", got); end
  endtask

  task automatic test_overrun();
    int lat;
    int vc0;
    logic [15:0] got;
    do_reset();
    vc0 = valid_count;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      sample_tick = (k == 3);
      if (sample_valid && lat < 0) lat = k;
      step();
    end
    sample_tick = 1'b0;
    vectors++;
    if (lat !== 7) begin miscompares++; $display("[TB] FAIL overrun_latency: got %0d expected 7", lat); end
    vectors++;
    if (valid_count - vc0 !== 1) begin miscompares++; $display("[TB] FAIL overrun_pulses: got %0d expected 1", valid_count - vc0); end
    vectors++;
    if (overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL overrun_flag: got %b expected 1", overrun); end
    run_frame(lat, got);
    vectors++;
    if (overrun !== 1'b1 || got !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL overrun_sticky: got overrun=%b out=%h expected 1 0000", overrun, got);
    end
  endtask

  task automatic test_keyoff_race();
    int lat;
    logic [15:0] got;
    do_reset();
    write_voice(0, 24'h100000, 16'hFFFF, SAW, 1'b1);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    cfg_voice = 2'd0; cfg_freq = 24'h100000; cfg_amp = 16'hFFFF; cfg_shape = 2'(SAW); cfg_key_on = 1'b0;
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
    lat = -1;
    got = 'x;
    for (int k = 2; k <= 20; k++) begin
      if (sample_valid) begin lat = k; got = sample_out; step(); break; end
      step();
    end
    vectors++;
    if (lat !== 7 || got !== 16'h9000) begin
      miscompares++;
      $display("[TB] FAIL race_old_values: got lat=%0d out=%h expected lat=7 out=9000", lat, got);
    end
    run_frame(lat, got);
    vectors++;
    if (got !== 16'h0000) begin miscompares++; $display("[TB] FAIL race_keyed_off: got %h expected 0000", got); end
    write_voice(0, 24'h100000, 16'hFFFF, SAW, 1'b1);
    run_frame(lat, got);
    vectors++;
    if (got !== 16'h9000) begin miscompares++; $display("[TB] FAIL race_phase_cleared: got %h expected 9000", got); end
  endtask

  task automatic test_random();
    int lat;
    int nw;
    int expv;
    logic [15:0] got;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        write_voice($urandom_range(0, NV - 1), $urandom & 32'h00FF_FFFF, $urandom_range(0, 65535),
                    $urandom_range(0, 3), ($urandom_range(0, 3) != 0));
      end
      expv = model_frame();
      run_frame(lat, got);
      vectors++;
      if (lat !== 7 || got !== 16'(expv)) begin
        miscompares++;
        $display("[TB] FAIL random_frame %0d: got lat=%0d out=%h expected lat=7 out=%h", it, lat, got, 16'(expv));
      end
    end
  endtask

  initial begin
    test_reset();
    test_silence();
    test_saw();
    test_saturate();
    test_wrap();
    test_overrun();
    test_keyoff_race();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
